exibidor_sequencia: RTL and testbench

Sequence playback engine for the memory game. On request it reads stored moves from the sequence memory, address 0 up to a given limit. Each move is shown on the LEDs for a fixed on-time, followed by a blanking gap, and a one-cycle `fim` pulse marks the end of playback. It is the responder that executes the "show sequence" phase, feeding the player-input control path.

---
 rtl/exibidor_sequencia.sv | 152 +++++++++++++++
 tb/tb_exibidor_sequencia.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia
//   Sequence playback engine for the memory game. On iniciar it walks the
//   sequence memory from address 0 up to the latched limite. Each move is
//   shown on the LEDs for TEMPO_ACESO cycles, followed by a TEMPO_APAGADO
//   dark gap. A one-cycle fim pulse marks the end of playback.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   iniciar      start request (only sampled while idle)
//   parar        synchronous abort, highest priority
//   limite       index of the last move to show (latched at start)
//   mem_endereco read address to the sequence memory
//   mem_dado     combinational read data for mem_endereco
//   leds         LED drive (nonzero only while a move is lit)
//   ocupado      high while playback is in progress
//   fim          one-cycle completion pulse
//   db_estado    current state code, for debug
module exibidor_sequencia #(
  parameter int ADDR_W        = 4,
  parameter int DADO_W        = 4,
  parameter int TEMPO_ACESO   = 1000,
  parameter int TEMPO_APAGADO = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [ADDR_W-1:0] limite,
  output logic [ADDR_W-1:0] mem_endereco,
  input  logic [DADO_W-1:0] mem_dado,
  output logic [DADO_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [3:0]        db_estado
);

  // The timer only ever holds 0 .. TEMPO-1, so this width cannot overflow.
  localparam int TEMPO_MAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
  localparam int TIMER_W   = $clog2(TEMPO_MAX + 1);

  localparam logic [TIMER_W-1:0] ULTIMO_ACESO   = TIMER_W'(TEMPO_ACESO - 1);
  localparam logic [TIMER_W-1:0] ULTIMO_APAGADO = TIMER_W'(TEMPO_APAGADO - 1);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    LE      = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  estado_t estado, estadoProx;

  logic [ADDR_W-1:0]  endereco,  enderecoProx;
  logic [ADDR_W-1:0]  limiteReg, limiteProx;
  logic [DADO_W-1:0]  ledReg,    ledProx;
  logic [TIMER_W-1:0] timer,     timerProx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      endereco  <= '0;
      limiteReg <= '0;
      ledReg    <= '0;
      timer     <= '0;
    end else begin
      estado    <= estadoProx;
      endereco  <= enderecoProx;
      limiteReg <= limiteProx;
      ledReg    <= ledProx;
      timer     <= timerProx;
    end
  end

  always_comb begin
    estadoProx   = estado;
    enderecoProx = endereco;
    limiteProx   = limiteReg;
    ledProx      = ledReg;
    timerProx    = timer;

    unique case (estado)
      OCIOSO: begin
        if (iniciar && !parar) begin
          limiteProx   = limite;
          enderecoProx = '0;
          timerProx    = '0;
          estadoProx   = LE;
        end
      end

      LE: begin
        ledProx    = mem_dado;
        estadoProx = ACESO;
      end

      ACESO: begin
        if (timer == ULTIMO_ACESO) begin
          timerProx  = '0;
          estadoProx = APAGADO;
        end else begin
          timerProx = timer + 1'b1;
        end
      end

      APAGADO: begin
        if (timer == ULTIMO_APAGADO) begin
          timerProx  = '0;
          estadoProx = PROXIMO;
        end else begin
          timerProx = timer + 1'b1;
        end
      end

      PROXIMO: begin
        // Compare before incrementing so the address stops at the limit
        // and never wraps, even when limite is all ones.
        if (endereco == limiteReg) begin
          estadoProx = FIM;
        end else begin
          enderecoProx = endereco + 1'b1;
          estadoProx   = LE;
        end
      end

      FIM: begin
        estadoProx = OCIOSO;
      end

      default: begin
        estadoProx = OCIOSO;
      end
    endcase

    // Abort overrides every transition; in OCIOSO it also blocks a start.
    if (parar) begin
      estadoProx = OCIOSO;
      timerProx  = '0;
      ledProx    = '0;
    end
  end

  assign mem_endereco = endereco;
  assign leds         = (estado == ACESO) ? ledReg : '0;
  assign ocupado      = (estado == LE) || (estado == ACESO) ||
                        (estado == APAGADO) || (estado == PROXIMO);
  assign fim          = (estado == FIM);
  assign db_estado    = estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// tb_exibidor_sequencia
//   Directed bench for exibidor_sequencia with TEMPO_ACESO=3, TEMPO_APAGADO=2.
//   Memory holds 0001,0010,0100,1000 at 0..3 and 0001 elsewhere. Cycle 1 is
//   the cycle after the edge that samples iniciar; each move takes 7 cycles.
module tb_exibidor_sequencia;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       parar;
  logic [3:0] limite;
  logic [3:0] mem_endereco;
  logic [3:0] mem_dado;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;

  logic [3:0] mem [16];

  int nChecks = 0;
  int nErrors = 0;

  exibidor_sequencia #(
    .ADDR_W(4),
    .DADO_W(4),
    .TEMPO_ACESO(3),
    .TEMPO_APAGADO(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .parar(parar),
    .limite(limite),
    .mem_endereco(mem_endereco),
    .mem_dado(mem_dado),
    .leds(leds),
    .ocupado(ocupado),
    .fim(fim),
    .db_estado(db_estado)
  );

  assign mem_dado = mem[mem_endereco];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand schedule: per move LE(1), ACESO(3), APAGADO(2), PROXIMO(1); then FIM.
  function automatic int expEstado(int c, int n);
    int p;
    if (c <= 7 * n) begin
      p = (c - 1) % 7;
      if (p == 0) return 1;
      if (p <= 3) return 2;
      if (p <= 5) return 3;
      return 4;
    end
    if (c == 7 * n + 1) return 5;
    return 0;
  endfunction

  function automatic int padrao(int m);
    if (m == 0) return 1;
    if (m == 1) return 2;
    if (m == 2) return 4;
    if (m == 3) return 8;
    return 1;
  endfunction

  task automatic startRun(input logic [3:0] lim);
    @(negedge clock);
    limite  = lim;
    iniciar = 1'b1;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
  endtask

  // Checks cycles 1..lastCycle of a run of n moves; returns at cycle lastCycle+1.
  task automatic runCycles(input string tag, input int n, input int lastCycle,
                           input int pulseAt, input int limAt);
    int st;
    int ad;
    for (int c = 1; c <= lastCycle; c++) begin
      st = expEstado(c, n);
      ad = (c <= 7 * n) ? (c - 1) / 7 : n - 1;
      checkVal($sformatf("%s estado c%0d", tag, c), 32'(db_estado), 32'(st));
      checkVal($sformatf("%s leds c%0d", tag, c), 32'(leds),
               (st == 2) ? 32'(padrao((c - 1) / 7)) : 32'd0);
      checkVal($sformatf("%s ocupado c%0d", tag, c), 32'(ocupado),
               (st >= 1 && st <= 4) ? 32'd1 : 32'd0);
      checkVal($sformatf("%s fim c%0d", tag, c), 32'(fim), (st == 5) ? 32'd1 : 32'd0);
      checkVal($sformatf("%s endereco c%0d", tag, c), 32'(mem_endereco), 32'(ad));
      iniciar = (c == pulseAt);
      if (c == limAt) limite = 4'd0;
      @(posedge clock);
      #1;
    end
    iniciar = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, " estado"}, 32'(db_estado), 32'd0);
    checkVal({tag, " leds"}, 32'(leds), 32'd0);
    checkVal({tag, " ocupado"}, 32'(ocupado), 32'd0);
    checkVal({tag, " fim"}, 32'(fim), 32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < 16; i++) mem[i] = 4'b0001;
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    mem[3] = 4'b1000;

    reset   = 1'b0;
    iniciar = 1'b0;
    parar   = 1'b0;
    limite  = 4'd0;

    // 1. Reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkIdle("reset");
    checkVal("reset endereco", 32'(mem_endereco), 32'd0);

    // 2. Single move
    startRun(4'd0);
    runCycles("um", 1, 9, -1, -1);

    // 3. Four moves; iniciar during FIM (cycle 29) must be ignored
    startRun(4'd3);
    runCycles("quatro", 4, 31, 29, -1);

    // 4. iniciar re-pulse and limite change mid-run are ignored
    startRun(4'd3);
    runCycles("ignora", 4, 30, 10, 12);

    // 4b. parar during ACESO
    startRun(4'd3);
    runCycles("parar", 4, 2, -1, -1);
    checkVal("parar pre estado", 32'(db_estado), 32'd2);
    parar = 1'b1;
    @(posedge clock);
    #1;
    parar = 1'b0;
    checkIdle("parar pos");
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      checkVal($sformatf("parar sem fim %0d", k), 32'(fim), 32'd0);
    end

    // parar together with iniciar in OCIOSO keeps it idle
    @(negedge clock);
    iniciar = 1'b1;
    parar   = 1'b1;
    limite  = 4'd3;
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    parar   = 1'b0;
    checkIdle("parar+iniciar");

    // 5. Asynchronous reset mid-APAGADO of move 2
    startRun(4'd3);
    runCycles("rst", 4, 11, -1, -1);
    checkVal("rst pre estado", 32'(db_estado), 32'd3);
    checkVal("rst pre endereco", 32'(mem_endereco), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkIdle("rst async");
    checkVal("rst async endereco", 32'(mem_endereco), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    startRun(4'd3);
    runCycles("pos rst", 4, 9, -1, -1);
    parar = 1'b1;
    @(posedge clock);
    #1;
    parar = 1'b0;

    // 6. limite = 15: no wrap, fim at 113, restart accepted at 114
    startRun(4'd15);
    runCycles("quinze", 16, 114, 114, -1);
    checkVal("reinicio estado", 32'(db_estado), 32'd1);
    checkVal("reinicio endereco", 32'(mem_endereco), 32'd0);
    checkVal("reinicio ocupado", 32'(ocupado), 32'd1);
    parar = 1'b1;
    @(posedge clock);
    #1;
    parar = 1'b0;
    checkIdle("fim final");

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
